trigger_cmd_sequencer: RTL and testbench
========================================

// Module: trigger_cmd_sequencer
// PURPOSE
//  Consumes the 16-bit one-cycle trigger vector produced by the Trigger-In endpoint (ep_clk domain).
//  Latches each pulse as a pending command, round-robin arbitrates, and issues one command id at a
//  time to the application engine via valid/ready. Waits for the engine's done, then pulses a
//  completion bit suited to a Trigger-Out endpoint. Records lost triggers in sticky overflow flags.
// PARAMETERS
//  NUM_TRIG  16    trigger lines; fixed at 16 to match endpoint width
//  ID_W      4     command id width; equals $clog2(NUM_TRIG)
//  TIMEOUT   1024  cycles to wait for cmd_done; used only with TRIG_TIMEOUT_EN; must be >= 2
// PORTS
//  ep_clk      in   1         sole clock (endpoint clock)
//  ep_rst_n    in   1         asynchronous, active-low reset
//  ep_trigger  in   NUM_TRIG  one-cycle trigger pulses from the Trigger-In endpoint
//  cmd_valid   out  1         command offered to the engine
//  cmd_id      out  ID_W      index of the offered trigger bit
//  cmd_ready   in   1         engine accepts; transfer happens when cmd_valid & cmd_ready
//  cmd_done    in   1         one-cycle pulse: accepted command finished
//  trig_done   out  NUM_TRIG  one-cycle completion pulse, bit = completed cmd_id
//  ovf_flags   out  NUM_TRIG  sticky: trigger arrived while that bit was already pending
//  ovf_clr     in   NUM_TRIG  write-1-to-clear for ovf_flags
//  busy        out  1         high in any state other than IDLE
//  timeout_err out  1         sticky timeout flag (TRIG_TIMEOUT_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream):
//   - pending, ovf_flags, trig_done, cmd_valid, cmd_id, timeout_err, and the rr pointer reset to 0.
//   - State resets to IDLE.
//  Pending: pending <= (pending & ~grant_clr) | ep_trigger.
//   - A bit set and cleared in the same cycle stays set; the new trigger is kept.
//  Overflow: ovf_flags[i] sets when ep_trigger[i] & pending[i] & ~grant_clr[i].
//   - If set and clear hit the same cycle, set wins.
//  FSM:
//   - IDLE: if pending != 0, select the first set bit at or after rr_ptr (wrapping 15->0).
//     Load cmd_id, clear that pending bit (grant_clr), assert cmd_valid, go to ISSUE.
//     Latency is 1 cycle from pending to cmd_valid.
//   - ISSUE: hold cmd_valid and cmd_id stable until cmd_ready. On the handshake, drop cmd_valid,
//     set rr_ptr = cmd_id+1 (mod 16), and go to WAIT.
//   - WAIT: on cmd_done, pulse trig_done[cmd_id] for exactly 1 cycle and return to IDLE.
//     The next grant can occur in the cycle after the pulse.
//  Rules:
//   - cmd_done outside WAIT is ignored.
//   - cmd_ready while cmd_valid is low is ignored.
//   - Reset mid-command drops everything; no trig_done is issued.
//   - All 16 triggers in one cycle are served in order 0..15, 16 commands total; none are lost.
// CONFIGURATION
//  TRIG_TIMEOUT_EN defined:
//   - An ID_W-independent counter ($clog2(TIMEOUT)+1 bits) runs in WAIT.
//   - Reaching TIMEOUT-1 without cmd_done sets timeout_err (sticky until reset) and pulses
//     trig_done[cmd_id] anyway, then returns to IDLE.
//   - cmd_done arriving in that same cycle counts as normal completion; no error.
//  TRIG_TIMEOUT_EN undefined: no counter; WAIT lasts until cmd_done; timeout_err is constant 0.
// STRUCTURE
//  Shared package trig_seq_pkg:
//   - state enum {IDLE, ISSUE, WAIT}
//   - NUM_TRIG and ID_W constants
//  One sub-module, rr_arbiter16: pending + rr_ptr in, combinational one-hot grant and index out.
//  FSM, pending/overflow registers and the timeout counter live in the top.
// TESTING
//  1 Single trigger: ep_trigger=16'h0010 with cmd_ready=1 -> cmd_valid next cycle, cmd_id=4;
//    cmd_done -> trig_done=16'h0010 for 1 cycle.
//  2 Burst: ep_trigger=16'hFFFF in one cycle -> ids 0,1,...,15 issued in order; ovf_flags stay 0.
//  3 Overflow: trigger bit 3 twice while pending -> ovf_flags[3]=1; ovf_clr=16'h0008 -> 0.
//    Set and clear in the same cycle -> stays 1.
//  4 Backpressure: cmd_ready=0 for 5 cycles -> cmd_valid and cmd_id stable; rr_ptr unchanged
//    until the handshake.
//  5 Round-robin: pending bits 2 and 9, last grant 5 -> 9 is served before 2.
//  6 Reset mid-WAIT: ep_rst_n low -> all outputs 0 immediately. A late cmd_done -> no trig_done.
//    With TRIG_TIMEOUT_EN and TIMEOUT=8 and no cmd_done -> timeout_err=1 after 8 WAIT cycles.

Source files
------------

// File: rtl/trig_seq_pkg.sv
// rtl/trig_seq_pkg.sv - shared types and constants for the trigger command sequencer
package trig_seq_pkg;

  localparam int NUM_TRIG = 16;
  localparam int ID_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic logic [NUM_TRIG-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NUM_TRIG'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arbiter16.sv
// rtl/rr_arbiter16.sv - round-robin pick of the first pending bit at or after rr_ptr
module rr_arbiter16
  import trig_seq_pkg::*;
(
  input  logic [NUM_TRIG-1:0] pending,
  input  logic [ID_W-1:0]     rr_ptr,
  output logic [NUM_TRIG-1:0] grant,
  output logic [ID_W-1:0]     grant_idx
);

  logic found;

  // Index arithmetic is ID_W wide, so rr_ptr + i wraps 15 -> 0 naturally.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (!found && pending[rr_ptr + ID_W'(i)]) begin
        found     = 1'b1;
        grant_idx = rr_ptr + ID_W'(i);
      end
    end
    grant = found ? id_to_onehot(grant_idx) : '0;
  end

endmodule

// File: rtl/trigger_cmd_sequencer.sv
// rtl/trigger_cmd_sequencer.sv - latches trigger pulses and issues them one at a time to an engine
// Optional WAIT timeout is enabled by defining TRIG_TIMEOUT_EN.
module trigger_cmd_sequencer
  import trig_seq_pkg::*;
`ifdef TRIG_TIMEOUT_EN
#(
  parameter int TIMEOUT = 1024
)
`endif
(
  input  logic                ep_clk,
  input  logic                ep_rst_n,
  input  logic [NUM_TRIG-1:0] ep_trigger,
  output logic                cmd_valid,
  output logic [ID_W-1:0]     cmd_id,
  input  logic                cmd_ready,
  input  logic                cmd_done,
  output logic [NUM_TRIG-1:0] trig_done,
  output logic [NUM_TRIG-1:0] ovf_flags,
  input  logic [NUM_TRIG-1:0] ovf_clr,
  output logic                busy,
  output logic                timeout_err
);

  state_t              state, state_n;
  logic [NUM_TRIG-1:0] pending;
  logic [NUM_TRIG-1:0] ovf_q;
  logic [NUM_TRIG-1:0] trig_done_q, trig_done_n;
  logic [NUM_TRIG-1:0] grant, grant_clr;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cmd_id_q, cmd_id_n;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
  logic                cmd_valid_q, cmd_valid_n;

`ifdef TRIG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             terr_q, terr_n;
`endif

  rr_arbiter16 u_arb (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_n     = state;
    cmd_valid_n = cmd_valid_q;
    cmd_id_n    = cmd_id_q;
    rr_ptr_n    = rr_ptr;
    trig_done_n = '0;
    grant_clr   = '0;
`ifdef TRIG_TIMEOUT_EN
    wait_cnt_n  = '0;
    terr_n      = terr_q;
`endif
    case (state)
      IDLE: begin
        if (|pending) begin
          grant_clr   = grant;
          cmd_id_n    = grant_idx;
          cmd_valid_n = 1'b1;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_n = 1'b0;
          rr_ptr_n    = cmd_id_q + ID_W'(1);
          state_n     = WAIT;
        end
      end
      WAIT: begin
        if (cmd_done) begin
          trig_done_n = id_to_onehot(cmd_id_q);
          state_n     = IDLE;
        end
`ifdef TRIG_TIMEOUT_EN
        // A timed-out command is still reported complete so the host is never left hanging.
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          trig_done_n = id_to_onehot(cmd_id_q);
          terr_n      = 1'b1;
          state_n     = IDLE;
        end else begin
          wait_cnt_n  = wait_cnt + CNT_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ep_clk or negedge ep_rst_n) begin
    if (!ep_rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      ovf_q       <= '0;
      trig_done_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_n;
      // A retrigger on the bit being granted this cycle is a fresh request, not an overflow.
      pending     <= (pending & ~grant_clr) | ep_trigger;
      ovf_q       <= (ovf_q & ~ovf_clr) | (ep_trigger & pending & ~grant_clr);
      trig_done_q <= trig_done_n;
      cmd_valid_q <= cmd_valid_n;
      cmd_id_q    <= cmd_id_n;
      rr_ptr      <= rr_ptr_n;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  always_ff @(posedge ep_clk or negedge ep_rst_n) begin
    if (!ep_rst_n) begin
      wait_cnt <= '0;
      terr_q   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      terr_q   <= terr_n;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign trig_done = trig_done_q;
  assign ovf_flags = ovf_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_trigger_cmd_sequencer.sv
// tb/tb_trigger_cmd_sequencer.sv - directed bench with a transaction-level reference model
module tb_trigger_cmd_sequencer;

  logic        ep_clk = 1'b0;
  logic        ep_rst_n;
  logic [15:0] ep_trigger;
  logic        cmd_valid;
  logic [3:0]  cmd_id;
  logic        cmd_ready;
  logic        cmd_done;
  logic [15:0] trig_done;
  logic [15:0] ovf_flags;
  logic [15:0] ovf_clr;
  logic        busy;
  logic        timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

`ifdef TRIG_TIMEOUT_EN
  localparam int TO = 8;
  trigger_cmd_sequencer #(.TIMEOUT(TO)) dut (
`else
  trigger_cmd_sequencer dut (
`endif
    .ep_clk      (ep_clk),
    .ep_rst_n    (ep_rst_n),
    .ep_trigger  (ep_trigger),
    .cmd_valid   (cmd_valid),
    .cmd_id      (cmd_id),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .trig_done   (trig_done),
    .ovf_flags   (ovf_flags),
    .ovf_clr     (ovf_clr),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 ep_clk = ~ep_clk;

  // Model: a set of pending requests, the command on offer, the command in flight.
  bit [15:0] m_pend, m_ovf, m_done;
  bit        m_offer, m_inflight, m_terr;
  int        m_id, m_next, m_wcnt;

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_done = '0;
    m_offer = 1'b0; m_inflight = 1'b0; m_terr = 1'b0;
    m_id = 0; m_next = 0; m_wcnt = 0;
  endtask

  task automatic model_step();
    bit [15:0] taken;
    bit [15:0] fin;
    bit        got;
    taken = '0;
    fin   = '0;
    got   = 1'b0;
    if (m_inflight) begin
      if (cmd_done) begin
        fin[m_id] = 1'b1;
        m_inflight = 1'b0;
      end
`ifdef TRIG_TIMEOUT_EN
      else if (m_wcnt == TO - 1) begin
        fin[m_id] = 1'b1;
        m_terr = 1'b1;
        m_inflight = 1'b0;
      end else begin
        m_wcnt++;
      end
`endif
    end else if (m_offer) begin
      if (cmd_ready) begin
        m_offer = 1'b0;
        m_inflight = 1'b1;
        m_next = (m_id + 1) % 16;
        m_wcnt = 0;
      end
    end else if (m_pend != 0) begin
      for (int k = 0; k < 16; k++) begin
        if (!got && m_pend[(m_next + k) % 16]) begin
          got = 1'b1;
          m_id = (m_next + k) % 16;
        end
      end
      taken[m_id] = 1'b1;
      m_offer = 1'b1;
    end
    m_ovf  = (m_ovf & ~ovf_clr) | (ep_trigger & m_pend & ~taken);
    m_pend = (m_pend & ~taken) | ep_trigger;
    m_done = fin;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge ep_clk);
      if (chk_en) begin
        check("cmd_valid", 16'(cmd_valid), 16'(m_offer));
        if (m_offer) check("cmd_id", 16'(cmd_id), 16'(m_id));
        check("trig_done", trig_done, m_done);
        check("ovf_flags", ovf_flags, m_ovf);
        check("busy", 16'(busy), 16'(m_offer | m_inflight));
        check("timeout_err", 16'(timeout_err), 16'(m_terr));
      end
    end
  end

  task automatic tick(input logic [15:0] t, input logic r, input logic d, input logic [15:0] c);
    ep_trigger = t; cmd_ready = r; cmd_done = d; ovf_clr = c;
    @(posedge ep_clk);
    if (ep_rst_n) model_step(); else model_reset();
    @(negedge ep_clk);
  endtask

  // Serve one command: wait for the offer, stall ready for 'stall' cycles, accept, then complete.
  task automatic serve_one(output int id, input int stall);
    int n;
    n = 0;
    while (!cmd_valid && n < 20) begin
      tick('0, 1'b0, 1'b0, '0);
      n++;
    end
    if (!cmd_valid) begin
      miscompares++;
      vectors++;
      $display("FAIL serve_wait: got cmd_valid=0 expected 1 within 20 cycles");
    end
    id = int'(cmd_id);
    repeat (stall) tick('0, 1'b0, 1'b0, '0);
    if (stall > 0) check("stall_id", 16'(cmd_id), 16'(id));
    tick('0, 1'b1, 1'b0, '0);
    tick('0, 1'b0, 1'b0, '0);
    tick('0, 1'b0, 1'b1, '0);
  endtask

  task automatic do_reset();
    #2 ep_rst_n = 1'b0;
    #1;
    check("rst_valid", 16'(cmd_valid), 16'h0);
    check("rst_id", 16'(cmd_id), 16'h0);
    check("rst_done", trig_done, 16'h0);
    check("rst_ovf", ovf_flags, 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    model_reset();
    @(negedge ep_clk);
    tick('0, 1'b0, 1'b0, '0);
    ep_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    ep_rst_n = 1'b0; ep_trigger = '0; cmd_ready = 1'b0; cmd_done = 1'b0; ovf_clr = '0;
    model_reset();
    repeat (2) @(negedge ep_clk);
    check("init_valid", 16'(cmd_valid), 16'h0);
    check("init_busy", 16'(busy), 16'h0);
    check("init_ovf", ovf_flags, 16'h0);
    check("init_terr", 16'(timeout_err), 16'h0);
    ep_rst_n = 1'b1;
    chk_en = 1'b1;

    // Burst of all 16 from reset: served 0..15, no overflow.
    tick(16'hFFFF, 1'b0, 1'b0, '0);
    for (int n = 0; n < 16; n++) begin
      serve_one(id, 0);
      check("burst_order", 16'(id), 16'(n));
    end
    check("burst_ovf", ovf_flags, 16'h0);

    // Single trigger on bit 4; ready already high before the offer.
    tick(16'h0010, 1'b1, 1'b0, '0);
    tick('0, 1'b1, 1'b0, '0);
    check("single_valid", 16'(cmd_valid), 16'h1);
    check("single_id", 16'(cmd_id), 16'h4);
    tick('0, 1'b1, 1'b0, '0);
    tick('0, 1'b0, 1'b1, '0);
    check("single_done", trig_done, 16'h0010);
    tick('0, 1'b1, 1'b1, '0);
    check("single_done_once", trig_done, 16'h0000);

    // Round-robin: last grant 5, then 2 and 9 together -> 9 first.
    tick(16'h0020, 1'b0, 1'b0, '0);
    serve_one(id, 0);
    check("rr_prev", 16'(id), 16'h5);
    tick(16'h0204, 1'b0, 1'b0, '0);
    serve_one(id, 0);
    check("rr_first", 16'(id), 16'h9);
    serve_one(id, 0);
    check("rr_second", 16'(id), 16'h2);

    // Overflow on bit 3 while the engine holds bit 0 in ISSUE.
    tick(16'h0001, 1'b0, 1'b0, '0);
    tick('0, 1'b0, 1'b0, '0);
    tick(16'h0008, 1'b0, 1'b0, '0);
    tick(16'h0008, 1'b0, 1'b0, '0);
    check("ovf_set", ovf_flags, 16'h0008);
    tick(16'h0008, 1'b0, 1'b0, 16'h0008);
    check("ovf_set_wins", ovf_flags, 16'h0008);
    tick('0, 1'b0, 1'b0, 16'h0008);
    check("ovf_clr", ovf_flags, 16'h0000);
    serve_one(id, 5);
    check("bp_id", 16'(id), 16'h0);
    serve_one(id, 0);
    check("ovf_served", 16'(id), 16'h3);

`ifdef TRIG_TIMEOUT_EN
    tick(16'h0080, 1'b0, 1'b0, '0);
    tick('0, 1'b0, 1'b0, '0);
    tick('0, 1'b1, 1'b0, '0);
    repeat (7) tick('0, 1'b0, 1'b0, '0);
    check("to_not_yet", 16'(timeout_err), 16'h0);
    tick('0, 1'b0, 1'b0, '0);
    check("to_err", 16'(timeout_err), 16'h1);
    check("to_done", trig_done, 16'h0080);
`endif

    // Reset while in WAIT; a late done must not complete anything.
    tick(16'h0040, 1'b0, 1'b0, '0);
    tick('0, 1'b0, 1'b0, '0);
    tick('0, 1'b1, 1'b0, '0);
    tick('0, 1'b0, 1'b0, '0);
    check("pre_rst_busy", 16'(busy), 16'h1);
    do_reset();
    tick('0, 1'b1, 1'b1, '0);
    check("late_done", trig_done, 16'h0000);
    check("late_busy", 16'(busy), 16'h0);
    repeat (2) tick('0, 1'b0, 1'b0, '0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
